// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock-enable divider with square-wave outputs,
// plus a free-running counter whose scan tap drives the display multiplexer.
module freq_div_multi #(
  parameter int CNT_W    = 26,
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int DEF_DIV  = 40000000,
  parameter int SCAN_LSB = 16,
  parameter int SCAN_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NCH-1:0]    pend,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    clk_out,
  output logic [CNT_W-1:0]  free_cnt,
  output logic [SCAN_W-1:0] scan
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

  logic [CNT_W-1:0] free_cnt_q, free_cnt_d;

  assign free_cnt_d = free_cnt_q + ONE_V;

  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt_q <= '0;
    end else begin
      free_cnt_q <= free_cnt_d;
    end
  end

  assign free_cnt = free_cnt_q;
  assign scan     = free_cnt_q[SCAN_LSB +: SCAN_W];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic [CNT_W-1:0] last_cnt;
    logic             wr_hit;
    logic             term;

    // Channel indices >= NCH have no matching generate block, so such writes fall away.
    assign wr_hit   = wr && (wr_ch == CH_W'(gi));
    // A ratio of 0 behaves as 1, so the last count value is 0 in both cases.
    assign last_cnt = (div_q == '0) ? '0 : (div_q - ONE_V);
    // ">=" also catches a counter stranded above a freshly loaded smaller ratio.
    assign term     = (cnt_q >= last_cnt);

    always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      tick_d   = 1'b0;
      clk_d    = clk_q;
      if (en && term) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = ~clk_q;
        if (wr_hit) begin
          div_d  = wr_div;
          pend_d = 1'b0;
        end else if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
      end else begin
        if (en) begin
          cnt_d = cnt_q + ONE_V;
        end
        // Last write wins while a ratio is still waiting for the period boundary.
        if (wr_hit) begin
          shadow_d = wr_div;
          pend_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        div_q    <= DEF_DIV_V;
        shadow_q <= DEF_DIV_V;
        pend_q   <= 1'b0;
        tick_q   <= 1'b0;
        clk_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        tick_q   <= tick_d;
        clk_q    <= clk_d;
      end
    end

    assign pend[gi]    = pend_q;
    assign tick[gi]    = tick_q;
    assign clk_out[gi] = clk_q;
  end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi: per-cycle tick/pend/clk_out bitmaps
// are compared against hand-computed masks (bit k = value after edge k).
module tb_freq_div_multi;

  localparam int CNT_W    = 8;
  localparam int NCH      = 2;
  localparam int CH_W     = 2;
  localparam int DEF_DIV  = 5;
  localparam int SCAN_LSB = 2;
  localparam int SCAN_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              wr;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_div;
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    clk_out;
  logic [CNT_W-1:0]  free_cnt;
  logic [SCAN_W-1:0] scan;

  always #5 clk = ~clk;

  freq_div_multi #(
    .CNT_W(CNT_W), .NCH(NCH), .CH_W(CH_W), .DEF_DIV(DEF_DIV),
    .SCAN_LSB(SCAN_LSB), .SCAN_W(SCAN_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_ch(wr_ch), .wr_div(wr_div),
    .pend(pend), .tick(tick), .clk_out(clk_out), .free_cnt(free_cnt), .scan(scan)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [63:0] tm0, tm1, pm0, pm1, cm0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("check %-14s ok  val=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 64) begin
      tm0[cyc] = tick[0];
      tm1[cyc] = tick[1];
      pm0[cyc] = pend[0];
      pm1[cyc] = pend[1];
      cm0[cyc] = clk_out[0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr  = 1'b0;
    en  = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
    tm0 = '0; tm1 = '0; pm0 = '0; pm1 = '0; cm0 = '0;
    chk("rst_tick", 64'(tick), 64'h0);
    chk("rst_clkout", 64'(clk_out), 64'h0);
    chk("rst_pend", 64'(pend), 64'h0);
    chk("rst_free", 64'(free_cnt), 64'h0);
  endtask

  task automatic write(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv);
    wr     = 1'b1;
    wr_ch  = ch;
    wr_div = dv;
    step();
    wr     = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wr = 1'b0; wr_ch = '0; wr_div = '0;

    // 1: default ratio 5 on both channels, free counter and scan tap
    do_reset();
    repeat (15) step();
    chk("t1_tick0", tm0, 64'h8420);
    chk("t1_tick1", tm1, 64'h8420);
    chk("t1_clkout0", cm0, 64'h83E0);
    chk("t1_clkout", 64'(clk_out), 64'h3);
    chk("t1_free15", 64'(free_cnt), 64'd15);
    chk("t1_scan15", 64'(scan), 64'd3);
    repeat (240) step();
    chk("t1_free255", 64'(free_cnt), 64'd255);
    chk("t1_scan255", 64'(scan), 64'd3);
    step();
    chk("t1_wrap", 64'(free_cnt), 64'd0);
    chk("t1_scanwrap", 64'(scan), 64'd0);

    // 2: ratio 3 written mid-period, applied at the next boundary
    do_reset();
    repeat (2) step();
    write(2'd0, 8'd3);
    repeat (9) step();
    chk("t2_tick0", tm0, 64'h920);
    chk("t2_pend0", pm0, 64'h18);
    chk("t2_tick1", tm1, 64'h420);
    chk("t2_pend1", pm1, 64'h0);

    // 3: write coincident with channel 1's terminal applies directly
    do_reset();
    repeat (4) step();
    write(2'd1, 8'd2);
    repeat (5) step();
    chk("t3_tick1", tm1, 64'h2A0);
    chk("t3_pend1", pm1, 64'h0);
    chk("t3_tick0", tm0, 64'h420);

    // 4: enable pauses, including one while clk_out is high
    do_reset();
    repeat (2) step();
    en = 1'b0;
    repeat (4) step();
    en = 1'b1;
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (6) step();
    chk("t4_tick0", tm0, 64'h20200);
    chk("t4_tick1", tm1, 64'h20200);
    chk("t4_clkout0", cm0, 64'h1FE00);

    // 5: ratio 0 behaves as 1; out-of-range channel write ignored
    do_reset();
    step();
    write(2'd0, 8'd0);
    write(2'd3, 8'd1);
    repeat (9) step();
    chk("t5_tick0", tm0, 64'h1FE0);
    chk("t5_clkout0", cm0, 64'hAA0);
    chk("t5_pend0", pm0, 64'h1C);
    chk("t5_tick1", tm1, 64'h420);
    chk("t5_pend1", pm1, 64'h0);

    // 6: two pending writes then a reset discards them
    do_reset();
    step();
    write(2'd1, 8'd4);
    write(2'd1, 8'd7);
    chk("t6_pendset", 64'(pend), 64'h2);
    do_reset();
    repeat (11) step();
    chk("t6_tick0", tm0, 64'h420);
    chk("t6_tick1", tm1, 64'h420);
    chk("t6_pend1", pm1, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
